// File: rtl/onchip_mem_arbiter_if.sv
// Avalon-MM master-side bundle: command, write data, burst length, and the
// waitrequest/readdata/readdatavalid return path. master drives commands; slave answers.
interface onchip_mem_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byteenable;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic [3:0]          burstcount;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;

  modport master (
    output address, byteenable, read, write,
    output writedata, burstcount,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write,
    input  writedata, burstcount,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/onchip_mem_arbiter.sv
// Round-robin two-master arbiter with burst sequencer for one on-chip RAM port.
// Ports: clk, reset_n (sync, active-low), m0/m1 slave bundles, mem_* RAM port.
module onchip_mem_arbiter #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  onchip_mem_arbiter_if.slave m0,
  onchip_mem_arbiter_if.slave m1,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  input  logic [DATA_W-1:0]   mem_readdata,
  output logic                mem_clken
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE,
    RD_BURST,
    WR_BURST
  } state_t;

  state_t            state;
  logic              last_grant;
  logic              owner;
  logic [ADDR_W-1:0] addr_cnt;
  logic [3:0]        beats_left;
  logic              rd_vld;
  logic              rd_id;

  logic              req0;
  logic              req1;
  logic              sel;
  logic [ADDR_W-1:0] s_addr;
  logic [BE_W-1:0]   s_be;
  logic              s_write;
  logic [DATA_W-1:0] s_data;
  logic [3:0]        s_bc;
  logic [3:0]        s_len;

  logic              o_write;
  logic [BE_W-1:0]   o_be;
  logic [DATA_W-1:0] o_data;

  logic              wait0;
  logic              wait1;
  logic              grant;
  logic              issue_rd;
  logic              step;

  assign req0 = m0.read | m0.write;
  assign req1 = m1.read | m1.write;

  // On a tie the master that did not win last time gets the port.
  assign sel = (req0 & req1) ? ~last_grant : req1;

  // A write request wins over a simultaneous read on the same master.
  assign s_addr  = sel ? m1.address    : m0.address;
  assign s_be    = sel ? m1.byteenable : m0.byteenable;
  assign s_write = sel ? m1.write      : m0.write;
  assign s_data  = sel ? m1.writedata  : m0.writedata;
  assign s_bc    = sel ? m1.burstcount : m0.burstcount;

  assign o_write = owner ? m1.write      : m0.write;
  assign o_be    = owner ? m1.byteenable : m0.byteenable;
  assign o_data  = owner ? m1.writedata  : m0.writedata;

  always_comb begin
    s_len = s_bc;
    if (s_bc == 4'd0) begin
      s_len = 4'd1;
    end else if (s_bc > 4'(MAX_BURST)) begin
      s_len = 4'(MAX_BURST);
    end
  end

  always_comb begin
    wait0          = 1'b1;
    wait1          = 1'b1;
    grant          = 1'b0;
    issue_rd       = 1'b0;
    step           = 1'b0;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_address    = s_addr;
    mem_byteenable = s_be;
    mem_writedata  = s_data;
    if (reset_n) begin
      unique case (state)
        IDLE: begin
          if (req0 | req1) begin
            grant          = 1'b1;
            mem_chipselect = 1'b1;
            mem_write      = s_write;
            issue_rd       = ~s_write;
            if (sel) begin
              wait1 = 1'b0;
            end else begin
              wait0 = 1'b0;
            end
          end
        end
        RD_BURST: begin
          mem_chipselect = 1'b1;
          mem_address    = addr_cnt;
          mem_byteenable = '1;
          issue_rd       = 1'b1;
          step           = 1'b1;
        end
        WR_BURST: begin
          mem_address    = addr_cnt;
          mem_byteenable = o_be;
          mem_writedata  = o_data;
          // Write low from the owner is a stall: no access, no count.
          if (o_write) begin
            mem_chipselect = 1'b1;
            mem_write      = 1'b1;
            step           = 1'b1;
            if (owner) begin
              wait1 = 1'b0;
            end else begin
              wait0 = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      addr_cnt   <= '0;
      beats_left <= '0;
      rd_vld     <= 1'b0;
      rd_id      <= 1'b0;
    end else begin
      rd_vld <= issue_rd;
      rd_id  <= (state == IDLE) ? sel : owner;
      unique case (state)
        IDLE: begin
          if (grant) begin
            last_grant <= sel;
            owner      <= sel;
            addr_cnt   <= s_addr + 1'b1;
            beats_left <= s_len - 4'd1;
            if (s_len > 4'd1) begin
              state <= s_write ? WR_BURST : RD_BURST;
            end
          end
        end
        RD_BURST, WR_BURST: begin
          if (step) begin
            addr_cnt   <= addr_cnt + 1'b1;
            beats_left <= beats_left - 4'd1;
            if (beats_left == 4'd1) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read data returns straight from the RAM q; only the tagged master sees valid.
  assign m0.readdata      = mem_readdata;
  assign m1.readdata      = mem_readdata;
  assign m0.readdatavalid = reset_n & rd_vld & ~rd_id;
  assign m1.readdatavalid = reset_n & rd_vld & rd_id;
  assign m0.waitrequest   = wait0;
  assign m1.waitrequest   = wait1;
  assign mem_clken        = 1'b1;

endmodule
